// File: rtl/channel_sum_accum_if.sv
// Handshake/data bundle between the conv datapath and the channel-combine stage.
// The master drives pass control and beats; the slave returns status and the result.
interface channel_sum_accum_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IN_W   = 21,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned OUT_W  = 8
);
  logic                       start;
  logic [ACC_W-1:0]           bias;
  logic [4:0]                 cfg_shift;
  logic                       relu_en;
  logic                       in_valid;
  logic                       in_last;
  logic [NUM_CH*IN_W-1:0]     dot_flat;
  logic                       busy;
  logic                       out_valid;
  logic [OUT_W-1:0]           out_data;
  logic                       ovf;

  modport master (
    output start, bias, cfg_shift, relu_en, in_valid, in_last, dot_flat,
    input  busy, out_valid, out_data, ovf
  );

  modport slave (
    input  start, bias, cfg_shift, relu_en, in_valid, in_last, dot_flat,
    output busy, out_valid, out_data, ovf
  );
endinterface

// File: rtl/channel_sum_accum.sv
// Sums NUM_CH signed dot products per beat, accumulates a pass from a bias with
// saturation, then rounds, shifts, optionally ReLUs and clamps to OUT_W bits.
module channel_sum_accum #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned IN_W   = 21,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned OUT_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  channel_sum_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W:0]   LIM_U   = {{(ACC_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};
  localparam logic signed [ACC_W:0]   LIM_SP  = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0]   LIM_SN  = ~LIM_SP;

  state_e                   state_q, state_d;
  logic [4:0]               shift_q, shift_d;
  logic                     relu_q, relu_d;
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [ACC_W-1:0]  s1_sum_q, s1_sum_d;
  logic                     s2_fire_q, s2_fire_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;
  logic                     out_valid_q, out_valid_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;

  logic signed [IN_W-1:0]   ch;
  logic [ACC_W:0]           ext_sum;
  logic signed [ACC_W:0]    rnd, r, q;
  logic [OUT_W-1:0]         sat;
  logic                     beat_ok;

  // Stage 1: channel sum; a start in the same cycle drops the beat.
  always_comb begin
    ch       = '0;
    s1_sum_d = '0;
    beat_ok  = bus.in_valid && (state_q == ACCUM) && !bus.start;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      ch       = bus.dot_flat[c*IN_W +: IN_W];
      s1_sum_d = s1_sum_d + ACC_W'(ch);
    end
    s1_valid_d = beat_ok;
    s1_last_d  = bus.in_last;
  end

  // Stage 2: saturating accumulate, reloaded from bias on any start.
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    s2_fire_d = 1'b0;
    ext_sum   = {acc_q[ACC_W-1], acc_q} + {s1_sum_q[ACC_W-1], s1_sum_q};
    if (bus.start) begin
      acc_d = bus.bias;
      ovf_d = 1'b0;
    end else if (s1_valid_q) begin
      s2_fire_d = s1_last_q;
      if (ext_sum[ACC_W] != ext_sum[ACC_W-1]) begin
        acc_d = ext_sum[ACC_W] ? ACC_MIN : ACC_MAX;
        ovf_d = 1'b1;
      end else begin
        acc_d = ext_sum[ACC_W-1:0];
      end
    end
  end

  // Stage 3: round half up in ACC_W+1 bits, arithmetic shift, clamp.
  always_comb begin
    rnd = '0;
    if (shift_q != 5'd0) rnd = (ACC_W+1)'(1) << (shift_q - 5'd1);
    r = {acc_q[ACC_W-1], acc_q} + rnd;
    q = r >>> shift_q;
    if (relu_q) begin
      if (q[ACC_W])        sat = '0;
      else if (q > LIM_U)  sat = '1;
      else                 sat = q[OUT_W-1:0];
    end else begin
      if (q > LIM_SP)      sat = {1'b0, {(OUT_W-1){1'b1}}};
      else if (q < LIM_SN) sat = {1'b1, {(OUT_W-1){1'b0}}};
      else                 sat = q[OUT_W-1:0];
    end
    out_valid_d = s2_fire_q && !bus.start;
    out_data_d  = out_valid_d ? sat : out_data_q;
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    relu_d  = relu_q;
    if (bus.start) begin
      state_d = ACCUM;
      shift_d = bus.cfg_shift;
      relu_d  = bus.relu_en;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        ACCUM:   if (beat_ok && bus.in_last) state_d = DRAIN;
        DRAIN:   if (out_valid_d) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      s2_fire_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_sum_q    <= s1_sum_d;
      s2_fire_q   <= s2_fire_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/channel_sum_accum.md
# channel_sum_accum

- Parametrised channel-combine and compress stage for the conv datapath.
- Sums NUM_CH signed per-channel dot products per beat and accumulates beats over a multi-beat pass, starting from a programmable bias.
- At the last beat, applies a rounding right shift, optional ReLU and saturation to OUT_W bits.
- Emits one registered result with a single-cycle valid pulse. Replaces fixed 3-channel, fixed-count sum/compress logic upstream of the output buffer.

## Interface
- NUM_CH, 3: number of input channels summed per beat (1..16)
- IN_W, 21: width of each signed channel dot product
- ACC_W, 24: signed accumulator width; must be ≥ IN_W + clog2(NUM_CH)
- OUT_W, 8: output width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  begin new pass; samples bias, cfg_shift, relu_en
- bias  in  ACC_W  signed initial accumulator value
- cfg_shift  in  5  arithmetic right-shift amount (0..ACC_W-1)
- relu_en  in  1  1: unsigned ReLU output; 0: signed output
- in_valid  in  1  beat valid
- in_last  in  1  marks final beat of pass; qualified by in_valid
- dot_flat  in  NUM_CH*IN_W  channel c at bits [c*IN_W +: IN_W], signed
- busy  out  1  high from accepted start until result issued
- out_valid  out  1  one-cycle pulse with result
- out_data  out  OUT_W  compressed result; held until next result
- ovf  out  1  sticky accumulator saturation flag for current pass; cleared by start

## Operation
- FSM states:
  - IDLE: busy=0, beats ignored; start -> ACCUM.
  - ACCUM: beats accepted; accepted in_last -> DRAIN.
  - DRAIN: pipeline empties, no new beats; out_valid -> IDLE.
- Config: bias, cfg_shift and relu_en are registered on start and held for the pass.
- Stage 1 (S1): register sum of all NUM_CH inputs, each sign-extended to ACC_W; carry the last flag.
- Stage 2 (S2): acc <= acc + S1 sum. acc is loaded with bias on start.
  - Add saturates at the signed ACC_W limits.
  - Any clamp sets ovf.
- Stage 3 (S3), on the last beat's S2 update:
  - r = acc + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0), computed in ACC_W+1 bits.
  - r is arithmetic-shifted right by cfg_shift (round half up).
  - relu_en=1: negative -> 0; clamp to [0, 2^OUT_W-1].
  - relu_en=0: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1], two's complement.
  - Register to out_data; pulse out_valid.
- start in ACCUM or DRAIN aborts the pass:
  - S1/S2 valid bits are cleared, acc is reloaded with bias, ovf is cleared.
  - No out_valid is produced for the aborted pass.
  - FSM enters ACCUM.
- start and in_valid in the same cycle: start wins; that beat is dropped.
- Beats with in_valid=1 outside ACCUM are dropped without effect.
- Single-beat pass (in_last on first beat) is legal.

## Timing
- Reset values: busy=0, out_valid=0, out_data=0, ovf=0, acc=0, FSM=IDLE, pipeline valids=0.
- Reset mid-pass aborts immediately; no output is produced.
- Throughput: one beat per cycle in ACCUM; no backpressure.
- Latency: accepted beat with in_last at edge T -> out_valid high during cycle T+3.
- busy falls in the same cycle out_valid is high.
- The next start is accepted in the cycle after out_valid. start during the out_valid cycle is treated as a new pass; the result is still issued.
- out_data changes only on the out_valid edge.
- ovf is observable from the cycle after the clamping add and stays set until start.

## Test plan
- Reset: assert rst_n=0 mid-pass -> all outputs 0 and FSM IDLE. A subsequent in_valid without start -> no out_valid.
- Single beat, bias=0, shift=0, relu=1, dots (10,20,30) with in_last -> out_data=60 (0x3C), out_valid exactly 3 cycles after the beat.
- Sign modes: dots (-100,0,0), shift=0. relu=1 -> 0x00; relu=0 -> 0x9C. relu=0 with dots (-300,0,0) -> 0x80.
- Multi-beat with rounding: bias=8, shift=4, relu=1, three beats of (100,100,100) -> acc=908, out_data=57 (0x39).
- Saturation: three beats each of (1048575,1048575,1048575), bias=0 -> acc clamps at 8388607, ovf=1, out_data=0xFF. The next start clears ovf.
- Abort: start, two beats of (5,5,5), then start again with bias=0, then one beat (1,2,3) with in_last -> single out_valid with out_data=6. start+in_valid in the same cycle -> beat dropped.
